serial_adder_n: RTL and testbench

//  Bit-serial N-bit adder/subtractor, successor to the single-bit full adder: one full-adder cell plus a carry flip-flop,

---
 rtl/serial_adder_n_pkg.sv | 10 +
 rtl/serial_adder_n_fa_bit.sv | 16 +
 rtl/serial_adder_n.sv | 114 +++++++++++
 tb/tb_serial_adder_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_adder_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_n_fa_bit.sv
// Combinational single-bit full adder cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry_out
);

  // Sum and carry of three input bits
  always_comb begin
    sum       = a ^ b ^ c_in;
    carry_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell plus a carry flop,
// one operand bit per clock, LSB first, with a start/done handshake.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;

  fa_bit u_fa (
    .a         (a_reg[0]),
    .b         (b_reg[0]),
    .c_in      (carry),
    .sum       (fa_sum),
    .carry_out (fa_carry)
  );

  assign sum = sum_reg;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus accept/last-bit strobes for the datapath
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/result shift registers, carry flop, bit counter and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      // Subtraction folds into addition: a + ~b + 1, the +1 seeded as carry-in
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (state == RUN) begin
      sum_reg <= {fa_sum, sum_reg[WIDTH-1:1]};
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      carry   <= fa_carry;
      cnt     <= cnt + 1'b1;
      if (last) begin
        // carry still holds the carry into the MSB on this edge
        cout <= fa_carry;
        ovf  <= carry ^ fa_carry;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n at WIDTH=4 and WIDTH=8.
module tb_serial_adder_n;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, sub4, start8, sub8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, cout4, ovf4;
  logic       busy8, done8, cout8, ovf8;
  logic [3:0] sum4;
  logic [7:0] sum8;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_n #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_adder_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("w4_unexpected_done", 32'(q4.size()), 1);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4_sum", 32'(sum4), 32'(e.s[3:0]));
        check("w4_cout", 32'(cout4), 32'(e.c));
        check("w4_ovf", 32'(ovf4), 32'(e.o));
        check("w4_latency", 32'(cyc - e.acc), 4);
        check("w4_busy_at_done", 32'(busy4), 0);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 32'(q8.size()), 1);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_sum", 32'(sum8), 32'(e.s));
        check("w8_cout", 32'(cout8), 32'(e.c));
        check("w8_ovf", 32'(ovf8), 32'(e.o));
        check("w8_latency", 32'(cyc - e.acc), 8);
      end
    end
  end

  // Drive an accept on dut4; returns 1 time unit after the accept edge
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [3:0] es, input logic ec, input logic eo);
    exp_t e;
    start4 = 1'b1; a4 = a; b4 = b; sub4 = s;
    @(posedge clk); #1;
    e.s = {4'b0, es}; e.c = ec; e.o = eo; e.acc = cyc;
    q4.push_back(e);
    start4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
    @(posedge clk); #1;
    e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
    q8.push_back(e);
    start8 = 1'b0;
  endtask

  // Bounded wait for done on dut4, returns at a falling edge
  task automatic wait_done4();
    int n = 0;
    @(negedge clk);
    while (done4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done8();
    int n = 0;
    @(negedge clk);
    while (done8 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_sum", 32'(sum4), 0);
    check("rst_cout", 32'(cout4), 0);
    check("rst_ovf", 32'(ovf4), 0);
    reset = 1'b0;
    @(negedge clk);

    // 5+3 = 8: signed overflow, busy for exactly 4 cycles
    issue4(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    check("t1_busy_c1", 32'(busy4), 1);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      check("t1_busy_run", 32'(busy4), 1);
    end
    @(posedge clk); #1;
    check("t1_busy_clear", 32'(busy4), 0);
    check("t1_done_high", 32'(done4), 1);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done4), 0);
    repeat (2) @(negedge clk);

    // 15+1 wraps to 0 with carry out
    issue4(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    wait_done4();
    repeat (2) @(negedge clk);

    // 3-5 borrows; -8-1 overflows
    issue4(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);
    wait_done4();
    @(negedge clk);
    issue4(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1);
    wait_done4();
    repeat (2) @(negedge clk);

    // Reset mid-run clears outputs immediately, then a normal operation
    issue4(4'b0110, 4'b0111, 1'b0, 4'b1101, 1'b0, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("t5_busy", 32'(busy4), 0);
    check("t5_done", 32'(done4), 0);
    check("t5_sum", 32'(sum4), 0);
    check("t5_cout", 32'(cout4), 0);
    check("t5_ovf", 32'(ovf4), 0);
    q4.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue4(4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0);
    wait_done4();
    repeat (2) @(negedge clk);

    // Start while busy ignored; start in DONE cycle accepted back-to-back
    issue4(4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; sub4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4();
    issue4(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    check("t4_b2b_busy", 32'(busy4), 1);
    check("t4_b2b_done_low", 32'(done4), 0);
    wait_done4();
    repeat (2) @(negedge clk);

    // WIDTH=8: 0x7F+1 overflows, done 8 edges after accept
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_done8();
    @(negedge clk);
    issue8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    wait_done8();
    repeat (3) @(negedge clk);

    check("w4_drained", 32'(q4.size()), 0);
    check("w8_drained", 32'(q8.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
